rr_mux2x1_stream: RTL and testbench
===================================

RR_MUX2X1_STREAM -- requirements
Module: rr_mux2x1_stream

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, data width of A, B and Y.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: A  input  WIDTH  source-A data; A_valid  input  1; A_ready  output  1.
REQ-005 SHALL have ports: B  input  WIDTH  source-B data; B_valid  input  1; B_ready  output  1.
REQ-006 SHALL have port: Lock  input  1  when 1, holds the current grant while that source keeps A_valid/B_valid high.
REQ-007 SHALL have ports: Y  output  WIDTH  registered selected data; Y_valid  output  1; Y_ready  input  1.
REQ-008 SHALL have port: Sel  output  1  source of the beat currently in Y (0=A, 1=B).

Function
REQ-009 SHALL define stage_free = !Y_valid || Y_ready; at most one input beat is accepted per cycle, and only when stage_free=1.
REQ-010 SHALL accept a beat on a source when its valid and ready are both 1 in the same cycle.
REQ-011 SHALL drive A_ready/B_ready combinationally: ready = stage_free && rst_n && (that source is granted); never both 1.
REQ-012 Grant rule: only A_valid -> A; only B_valid -> B; neither -> none.
REQ-013 Grant rule, both valid: state IDLE -> A; GRANT_A -> B; GRANT_B -> A (round robin).
REQ-014 Lock override: with Lock=1 and both valid, GRANT_A keeps A and GRANT_B keeps B; Lock has no effect in IDLE.
REQ-015 FSM states: IDLE, GRANT_A, GRANT_B; accept from A -> GRANT_A; accept from B -> GRANT_B.
REQ-016 FSM: when stage_free=1 and neither valid, the FSM SHALL go to IDLE; otherwise it holds state.
REQ-017 Latency: a beat accepted in cycle N SHALL appear on Y with Y_valid=1 in cycle N+1, with Sel = its source.
REQ-018 While Y_valid=1 and Y_ready=0, Y, Sel and Y_valid SHALL hold stable and no input SHALL be accepted.
REQ-019 Simultaneous output drain and input accept: Y SHALL reload in the same edge, with no bubble.
REQ-020 Output drained with no accept: Y_valid SHALL go to 0; Y and Sel SHALL hold their last values.
REQ-021 No beat SHALL be dropped or duplicated; Y passes data unmodified, WIDTH bits, with no arithmetic.

Reset
REQ-022 rst_n=0 SHALL immediately force Y=0, Y_valid=0, Sel=0, FSM=IDLE, and A_ready=B_ready=0.
REQ-023 Reset mid-transfer SHALL discard the beat held in Y.
REQ-024 After rst_n rises, the first accept SHALL follow the IDLE rule (A wins a tie).

Structure
REQ-025 Package mux_pkg SHALL hold the sel_e typedef (SEL_A=0, SEL_B=1) and the state_e typedef (IDLE, GRANT_A, GRANT_B).
REQ-026 Grant logic (REQ-012..014) SHALL be the combinational sub-module rr_grant2: inputs state, Lock, A_valid, B_valid; outputs gnt_a, gnt_b.
REQ-027 The top level SHALL hold the FSM register, the output data/valid/Sel register and the ready logic.

Verification (WIDTH=8)
REQ-028 Reset: rst_n=0 with A_valid=B_valid=1 -> Y=0x00, Y_valid=0, Sel=0, A_ready=B_ready=0.
REQ-029 Single source: A=0x5A, A_valid=1 for 1 cycle, Y_ready=1 -> next cycle Y=0x5A, Y_valid=1, Sel=0; following cycle Y_valid=0.
REQ-030 Round robin: from IDLE, A=0x11 and B=0x22 valid continuously, Y_ready=1 -> Y=0x11,0x22,0x11,0x22 on consecutive cycles; Sel=0,1,0,1.
REQ-031 Backpressure: Y=0x22 held with Y_valid=1 and Y_ready=0 for 3 cycles -> Y, Sel and Y_valid stable; A_ready=B_ready=0; Y_ready=1 -> next beat 0x11 follows immediately.
REQ-032 Lock: both valid, Lock=1 after an A grant -> three consecutive Y=0x11 beats with Sel=0; Lock=0 -> next beat 0x22 with Sel=1.
REQ-033 Reset mid-stream: rst_n pulsed low while Y_valid=1 holding 0x22 -> Y_valid=0 at once; after release, first beat with both valid is 0x11.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types for the two-input round-robin stream mux: source select
// encoding and the grant-history FSM states.
package mux_pkg;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

endpackage

// File: rtl/rr_mux2x1_stream_if.sv
// Stream bundle for the 2:1 mux: two valid/ready sources, the lock request,
// and the registered output stream with its source tag.
interface rr_mux2x1_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic             A_valid;
  logic             A_ready;
  logic [WIDTH-1:0] B;
  logic             B_valid;
  logic             B_ready;
  logic             Lock;
  logic [WIDTH-1:0] Y;
  logic             Y_valid;
  logic             Y_ready;
  logic             Sel;

  // Environment side: drives sources, lock and downstream ready.
  modport master (
    output A, A_valid, B, B_valid, Lock, Y_ready,
    input  A_ready, B_ready, Y, Y_valid, Sel
  );

  // Mux side: consumes sources, produces the output stream.
  modport slave (
    input  A, A_valid, B, B_valid, Lock, Y_ready,
    output A_ready, B_ready, Y, Y_valid, Sel
  );
endinterface

// File: rtl/rr_grant2.sv
// Combinational two-way grant: a lone requester always wins; on a tie the
// previous winner is rotated out unless Lock asks to keep it. From IDLE a
// tie goes to A regardless of Lock.
module rr_grant2
  import mux_pkg::*;
(
  input  state_e state,
  input  logic   Lock,
  input  logic   A_valid,
  input  logic   B_valid,
  output logic   gnt_a,
  output logic   gnt_b
);

  // Pick at most one source from the request pair and the grant history.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (A_valid && B_valid) begin
      case (state)
        GRANT_A: begin
          gnt_a = Lock;
          gnt_b = !Lock;
        end
        GRANT_B: begin
          gnt_a = !Lock;
          gnt_b = Lock;
        end
        default: gnt_a = 1'b1;
      endcase
    end else begin
      gnt_a = A_valid;
      gnt_b = B_valid;
    end
  end

endmodule

// File: rtl/rr_mux2x1_stream.sv
// Two-source round-robin stream multiplexer with a single registered output
// stage. One beat is taken per cycle whenever the output stage is empty or
// being drained, so full throughput is kept under continuous Y_ready.
module rr_mux2x1_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_mux2x1_stream_if.slave    bus
);

  state_e           state_reg, state_next;
  logic [WIDTH-1:0] y_reg;
  logic             y_valid_reg;
  sel_e             sel_reg;

  logic stage_free;
  logic gnt_a, gnt_b;
  logic accept_a, accept_b;

  assign stage_free = !y_valid_reg || bus.Y_ready;

  rr_grant2 u_grant (
    .state   (state_reg),
    .Lock    (bus.Lock),
    .A_valid (bus.A_valid),
    .B_valid (bus.B_valid),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  // Ready is withheld during reset so no beat can be handshaken then.
  assign bus.A_ready = stage_free && rst_n && gnt_a;
  assign bus.B_ready = stage_free && rst_n && gnt_b;

  assign accept_a = bus.A_valid && bus.A_ready;
  assign accept_b = bus.B_valid && bus.B_ready;

  assign bus.Y       = y_reg;
  assign bus.Y_valid = y_valid_reg;
  assign bus.Sel     = sel_reg;

  // Grant history: remember the last winner, fall back to IDLE when the
  // stage could take a beat but nobody is asking.
  always_comb begin
    state_next = state_reg;
    if (accept_a) begin
      state_next = GRANT_A;
    end else if (accept_b) begin
      state_next = GRANT_B;
    end else if (stage_free && !bus.A_valid && !bus.B_valid) begin
      state_next = IDLE;
    end
  end

  // FSM register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Output stage: load on accept, empty on drain, hold under backpressure.
  // Data and Sel keep their last values when the stage empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
      sel_reg     <= SEL_A;
    end else if (stage_free) begin
      if (accept_a) begin
        y_reg       <= bus.A;
        y_valid_reg <= 1'b1;
        sel_reg     <= SEL_A;
      end else if (accept_b) begin
        y_reg       <= bus.B;
        y_valid_reg <= 1'b1;
        sel_reg     <= SEL_B;
      end else begin
        y_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux2x1_stream.sv
// Directed bench for rr_mux2x1_stream: a cycle table covering single-source,
// round robin, backpressure and lock, plus hand-written reset sequences.
module tb_rr_mux2x1_stream;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_mux2x1_stream_if #(.WIDTH(8)) bus ();

  rr_mux2x1_stream #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic       av;
    logic [7:0] b;
    logic       bv;
    logic       lock;
    logic       yr;
    logic [7:0] ey;
    logic       eyv;
    logic       esel;
    logic       ear;
    logic       ebr;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] ey, input logic eyv,
                           input logic esel, input logic ear, input logic ebr);
    check({tag, ".Y"},       {24'd0, bus.Y}, {24'd0, ey});
    check({tag, ".Y_valid"}, {31'd0, bus.Y_valid}, {31'd0, eyv});
    check({tag, ".Sel"},     {31'd0, bus.Sel}, {31'd0, esel});
    check({tag, ".A_ready"}, {31'd0, bus.A_ready}, {31'd0, ear});
    check({tag, ".B_ready"}, {31'd0, bus.B_ready}, {31'd0, ebr});
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Each row: inputs applied for one cycle; expectations sampled before
    // the closing edge (Y shows the beat accepted in the previous row).
    //          a      av    b      bv    lk    yr    ey     eyv   sel   ar    br
    vecs[0]  = '{8'h5A, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{8'h5A, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h5A, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{8'h11, 1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset asserted while both sources request.
    rst_n       = 1'b1;
    bus.A       = 8'h11;
    bus.A_valid = 1'b1;
    bus.B       = 8'h22;
    bus.B_valid = 1'b1;
    bus.Lock    = 1'b0;
    bus.Y_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("txn reset: Y=%02h Y_valid=%0b Sel=%0b", bus.Y, bus.Y_valid, bus.Sel);
    @(posedge clk);
    @(posedge clk);
    bus.A_valid = 1'b0;
    bus.B_valid = 1'b0;
    #1 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      bus.A       = vecs[i].a;
      bus.A_valid = vecs[i].av;
      bus.B       = vecs[i].b;
      bus.B_valid = vecs[i].bv;
      bus.Lock    = vecs[i].lock;
      bus.Y_ready = vecs[i].yr;
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].ey, vecs[i].eyv, vecs[i].esel,
                vecs[i].ear, vecs[i].ebr);
      $display("txn vec%0d: Y=%02h Y_valid=%0b Sel=%0b A_ready=%0b B_ready=%0b",
               i, bus.Y, bus.Y_valid, bus.Sel, bus.A_ready, bus.B_ready);
      @(posedge clk);
      #1;
    end

    // Reset mid-stream: load 0x22 from B and hold it under backpressure.
    bus.A_valid = 1'b0;
    bus.B_valid = 1'b1;
    bus.Y_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.B_valid = 1'b0;
    bus.Y_ready = 1'b0;
    @(negedge clk);
    check_all("midrst_pre", 8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.A_valid = 1'b1;
    bus.B_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all("midrst_low", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("txn midrst: Y=%02h Y_valid=%0b Sel=%0b", bus.Y, bus.Y_valid, bus.Sel);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.Y_ready = 1'b1;
    @(negedge clk);
    check_all("post_rst_tie", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    bus.A_valid = 1'b0;
    bus.B_valid = 1'b0;
    @(negedge clk);
    check_all("post_rst_beat", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("txn post_rst: Y=%02h Y_valid=%0b Sel=%0b", bus.Y, bus.Y_valid, bus.Sel);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
